// File: rtl/sha256_pad_writer.sv
// sha256_pad_writer
// Streams message words into a word-addressed memory and then appends
// SHA-256 padding: a single 0x80000000 marker word, zero fill, and the
// 32-bit message bit length as the last word of the final 512-bit block.
//
// Input handshake: a word transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready is 1 exactly while the FSM sits in DATA and
// does not depend on in_valid; in_data/in_last are only looked at on such
// an edge, so in_valid may drop for any number of cycles without effect.
//
// Memory port: mem_we/mem_addr/mem_write_data are registered, so each write
// is presented during the cycle that follows the edge that produced it.
// The memory is expected to capture on mem_clk, which is clk.

module sha256_pad_writer #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        done,
  output logic [7:0]  num_blocks,
  output logic        overflow,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    PAD80 = 3'd2,
    ZERO  = 3'd3,
    LEN   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Word count limit; MAX_WORDS is at most 4095 so 13 bits never wrap.
  localparam logic [12:0] MAX_N = 13'(MAX_WORDS);

  localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

  state_t      state;
  logic [15:0] base;     // latched base_addr of the current message
  logic [12:0] n;        // message words accepted so far
  logic [15:0] ptr;      // word offset of the next zero-fill write

  logic [12:0] n_inc;
  logic [15:0] n_ext;
  logic [15:0] blocks;   // B = floor((N+2)/16)+1, up to 257
  logic [15:0] total;    // T = 16*B, offset just past the length word
  logic [15:0] zero_end; // offset of the final zero-fill word, T-2
  logic [15:0] len_off;  // offset of the length word, T-1
  logic [31:0] bit_len;  // N*32

  // Padding geometry derived from the current word count.
  assign n_inc    = n + 13'd1;
  assign n_ext    = {3'b000, n};
  assign blocks   = ((n_ext + 16'd2) >> 4) + 16'd1;
  assign total    = blocks << 4;
  assign zero_end = total - 16'd2;
  assign len_off  = total - 16'd1;
  assign bit_len  = {14'd0, n, 5'd0};

  assign mem_clk   = clk;
  assign in_ready  = (state == DATA);
  assign dbg_state = state;

  // Main FSM: every memory-port and status output is loaded here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      base           <= 16'd0;
      n              <= 13'd0;
      ptr            <= 16'd0;
      mem_we         <= 1'b0;
      mem_addr       <= 16'd0;
      mem_write_data <= 32'd0;
      done           <= 1'b0;
      num_blocks     <= 8'd0;
      overflow       <= 1'b0;
    end else begin
      // Strobes default low; only write-producing edges raise them.
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base       <= base_addr;
            n          <= 13'd0;
            overflow   <= 1'b0;
            num_blocks <= 8'd0;
            state      <= DATA;
          end
        end

        DATA: begin
          // in_ready is 1 here, so in_valid alone completes the handshake.
          if (in_valid) begin
            mem_we         <= 1'b1;
            mem_addr       <= base + n_ext;
            mem_write_data <= in_data;
            n              <= n_inc;
            if (in_last) begin
              state <= PAD80;
            end else if (n_inc == MAX_N) begin
              // Out of room: close the message as if this were the last word.
              overflow <= 1'b1;
              state    <= PAD80;
            end
          end
        end

        PAD80: begin
          mem_we         <= 1'b1;
          mem_addr       <= base + n_ext;
          mem_write_data <= PAD_MARKER;
          ptr            <= n_ext + 16'd1;
          state          <= ZERO;
        end

        ZERO: begin
          // T >= N+3 always holds, so at least one zero word is written.
          mem_we         <= 1'b1;
          mem_addr       <= base + ptr;
          mem_write_data <= 32'd0;
          ptr            <= ptr + 16'd1;
          if (ptr == zero_end) begin
            state <= LEN;
          end
        end

        LEN: begin
          mem_we         <= 1'b1;
          mem_addr       <= base + len_off;
          mem_write_data <= bit_len;
          state          <= DONE;
        end

        DONE: begin
          done       <= 1'b1;
          num_blocks <= blocks[7:0];
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_pad_writer.sv
// tb_sha256_pad_writer
// Table-driven bench: each vector runs one message through either the
// default instance (MAX_WORDS=1024) or a small one (MAX_WORDS=16), captures
// the written memory image, and compares it with an image built from the
// vector's hand-computed block count, length word and done timing.

module tb_sha256_pad_writer;

  localparam logic [31:0] SEED  = 32'h0123_4675;
  localparam logic [31:0] FILL  = 32'hDEAD_BEEF;
  localparam logic [2:0]  S_IDLE = 3'd0;
  localparam logic [2:0]  S_ZERO = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic        sel = 1'b0;     // 0: default instance, 1: MAX_WORDS=16 instance

  logic        in_ready0, mem_clk0, mem_we0, done0, overflow0;
  logic [15:0] mem_addr0;
  logic [31:0] mem_write_data0;
  logic [7:0]  num_blocks0;
  logic [2:0]  dbg_state0;

  logic        in_ready1, mem_clk1, mem_we1, done1, overflow1;
  logic [15:0] mem_addr1;
  logic [31:0] mem_write_data1;
  logic [7:0]  num_blocks1;
  logic [2:0]  dbg_state1;

  sha256_pad_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .mem_clk(mem_clk0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_write_data(mem_write_data0), .done(done0), .num_blocks(num_blocks0),
    .overflow(overflow0), .dbg_state(dbg_state0)
  );

  sha256_pad_writer #(.MAX_WORDS(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .mem_clk(mem_clk1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_write_data(mem_write_data1), .done(done1), .num_blocks(num_blocks1),
    .overflow(overflow1), .dbg_state(dbg_state1)
  );

  logic        in_ready_s, mem_we_s, done_s, overflow_s;
  logic [15:0] mem_addr_s;
  logic [31:0] mem_write_data_s;
  logic [7:0]  num_blocks_s;
  logic [2:0]  dbg_state_s;

  assign in_ready_s       = sel ? in_ready1       : in_ready0;
  assign mem_we_s         = sel ? mem_we1         : mem_we0;
  assign done_s           = sel ? done1           : done0;
  assign overflow_s       = sel ? overflow1       : overflow0;
  assign mem_addr_s       = sel ? mem_addr1       : mem_addr0;
  assign mem_write_data_s = sel ? mem_write_data1 : mem_write_data0;
  assign num_blocks_s     = sel ? num_blocks1     : num_blocks0;
  assign dbg_state_s      = sel ? dbg_state1      : dbg_state0;

  // ---------------- monitors / memory model ----------------
  logic        clr_mon = 1'b0;
  logic [31:0] mem [65536];
  int          edge_cnt, last_hs, wr_cnt, done_cnt, done_rel;

  always @(posedge clk) begin
    if (clr_mon) begin
      edge_cnt <= 0;
      last_hs  <= 0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (in_valid && in_ready_s) last_hs <= edge_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (clr_mon) begin
      for (int a = 0; a < 65536; a++) mem[a] <= FILL;
      wr_cnt   <= 0;
      done_cnt <= 0;
      done_rel <= 0;
    end else begin
      if (mem_we_s) begin
        mem[mem_addr_s] <= mem_write_data_s;
        wr_cnt          <= wr_cnt + 1;
      end
      if (done_s) begin
        done_cnt <= done_cnt + 1;
        if (done_cnt == 0) done_rel <= edge_cnt - last_hs + 1;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    logic [31:0] w;
    w = SEED;
    for (int k = 0; k < i; k++) w = {w[30:0], w[31]};
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sel;
    logic [15:0] base;
    int          n_offer;
    logic        use_last;
    logic        gap;
    int          exp_n;
    int          exp_blocks;
    int          exp_done;
    logic [31:0] exp_len;
    logic        exp_ovf;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [15:0] b, input int no,
                              input logic ul, input logic g, input int en, input int eb,
                              input int ed, input logic [31:0] el, input logic eo);
    vec_t v;
    v.sel = s; v.base = b; v.n_offer = no; v.use_last = ul; v.gap = g;
    v.exp_n = en; v.exp_blocks = eb; v.exp_done = ed; v.exp_len = el; v.exp_ovf = eo;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Reset both instances, start a message and stream its words.
  task automatic feed_msg(input vec_t v, output int hs_got);
    int i;
    int cyc;
    logic hs;
    sel = v.sel;
    reset_n = 1'b0; clr_mon = 1'b1; start = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0;
    step();
    reset_n = 1'b1; clr_mon = 1'b0;
    start = 1'b1; base_addr = v.base;
    step();
    start = 1'b0;
    i = 0;
    cyc = 0;
    while (i < v.n_offer && cyc < 400) begin
      if (v.gap && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
        start    = 1'b1;   // ignored while busy
      end else begin
        in_valid = 1'b1;
        in_data  = word_at(i);
        in_last  = v.use_last && (i == v.n_offer - 1);
        start    = 1'b0;
      end
      hs = in_valid && in_ready_s;
      step();
      if (hs) i++;
      cyc++;
      if (!in_ready_s && i > 0) break;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    hs_got = i;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int hs_got;
    int cyc;
    int t;
    int bad_data, bad_zero;
    logic [15:0] a;
    feed_msg(v, hs_got);
    cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      if (v.gap && cyc == 2) start = 1'b1;
      else start = 1'b0;
      step();
      cyc++;
    end
    start = 1'b0;
    repeat (6) step();

    t = v.exp_blocks * 16;
    bad_data = 0;
    for (int i = 0; i < v.exp_n; i++) begin
      a = v.base + 16'(i);
      if (mem[a] !== word_at(i)) bad_data++;
    end
    bad_zero = 0;
    for (int i = v.exp_n + 1; i <= t - 2; i++) begin
      a = v.base + 16'(i);
      if (mem[a] !== 32'd0) bad_zero++;
    end
    check($sformatf("v%0d_handshakes", k), 32'(hs_got), 32'(v.exp_n));
    check($sformatf("v%0d_data_bad", k), 32'(bad_data), 32'd0);
    a = v.base + 16'(v.exp_n);
    check($sformatf("v%0d_pad80", k), mem[a], 32'h8000_0000);
    check($sformatf("v%0d_zero_bad", k), 32'(bad_zero), 32'd0);
    a = v.base + 16'(t - 1);
    check($sformatf("v%0d_len", k), mem[a], v.exp_len);
    a = v.base + 16'(t);
    check($sformatf("v%0d_guard", k), mem[a], FILL);
    check($sformatf("v%0d_num_blocks", k), 32'(num_blocks_s), 32'(v.exp_blocks));
    check($sformatf("v%0d_overflow", k), 32'(overflow_s), 32'(v.exp_ovf));
    check($sformatf("v%0d_done_edge", k), 32'(done_rel), 32'(v.exp_done));
    check($sformatf("v%0d_done_cnt", k), 32'(done_cnt), 32'd1);
    check($sformatf("v%0d_write_cnt", k), 32'(wr_cnt), 32'(t));
    check($sformatf("v%0d_idle", k), 32'(dbg_state_s), 32'(S_IDLE));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[10];

  initial begin
    int   hs_got;
    int   cyc;
    int   snap;

    vecs[0] = mk(1'b0, 16'h0000, 30, 1'b1, 1'b0, 30, 3, 20, 32'h0000_03C0, 1'b0);
    vecs[1] = mk(1'b0, 16'd100,  13, 1'b1, 1'b0, 13, 1,  5, 32'h0000_01A0, 1'b0);
    vecs[2] = mk(1'b0, 16'h0000, 14, 1'b1, 1'b0, 14, 2, 20, 32'h0000_01C0, 1'b0);
    vecs[3] = mk(1'b0, 16'h0000, 30, 1'b1, 1'b1, 30, 3, 20, 32'h0000_03C0, 1'b0);
    vecs[4] = mk(1'b0, 16'hFFF8, 13, 1'b1, 1'b0, 13, 1,  5, 32'h0000_01A0, 1'b0);
    vecs[5] = mk(1'b0, 16'h0200,  1, 1'b1, 1'b0,  1, 1, 17, 32'h0000_0020, 1'b0);
    vecs[6] = mk(1'b0, 16'h0000, 15, 1'b1, 1'b0, 15, 2, 19, 32'h0000_01E0, 1'b0);
    vecs[7] = mk(1'b1, 16'h0000, 20, 1'b0, 1'b0, 16, 2, 18, 32'h0000_0200, 1'b1);
    vecs[8] = mk(1'b1, 16'h0000, 16, 1'b1, 1'b0, 16, 2, 18, 32'h0000_0200, 1'b0);
    vecs[9] = mk(1'b1, 16'h0040, 15, 1'b1, 1'b0, 15, 2, 19, 32'h0000_01E0, 1'b0);

    // Reset state.
    reset_n = 1'b0;
    step();
    step();
    check("rst_mem_we", 32'(mem_we0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd0);
    check("rst_overflow", 32'(overflow0), 32'd0);
    check("rst_num_blocks", 32'(num_blocks0), 32'd0);
    check("rst_mem_addr", 32'(mem_addr0), 32'd0);
    check("rst_mem_wdata", mem_write_data0, 32'd0);
    check("rst_state", 32'(dbg_state0), 32'(S_IDLE));
    reset_n = 1'b1;
    step();

    for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

    // Reset in the middle of zero fill, then a normal message.
    feed_msg(vecs[0], hs_got);
    cyc = 0;
    while (dbg_state_s != S_ZERO && cyc < 50) begin
      step();
      cyc++;
    end
    check("midrst_reach_zero", 32'(dbg_state_s), 32'(S_ZERO));
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_mem_we", 32'(mem_we_s), 32'd0);
    check("midrst_done", 32'(done_s), 32'd0);
    check("midrst_state", 32'(dbg_state_s), 32'(S_IDLE));
    check("midrst_mem_addr", 32'(mem_addr_s), 32'd0);
    check("midrst_mem_wdata", mem_write_data_s, 32'd0);
    snap = wr_cnt;
    repeat (60) step();
    check("midrst_no_writes", 32'(wr_cnt), 32'(snap));
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_vec(10, vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
